// File: rtl/shift_register_universal.sv
// shift_register_universal
//   WIDTH-bit universal register: hold, parallel load, logical shift left/right,
//   rotate left/right, with a saturating count of bits shifted out since the
//   last load or clear.
//
//   Optional feature macro: ARITH_SHIFT_EN
//     defined   -> Mode 110 is an arithmetic right shift (MSB replicated)
//     undefined -> Mode 110 behaves as hold
//
// Ports
//   Clock       in   rising-edge clock
//   Clear       in   synchronous active-high clear of all state
//   Enable      in   low: all state holds; high: Mode is acted on
//   Mode[2:0]   in   operation select
//   D           in   parallel load data
//   SerialInL   in   bit entering at the MSB on right shifts
//   SerialInR   in   bit entering at the LSB on left shifts
//   Q           out  register contents
//   SerialOut   out  last bit shifted or rotated out
//   ShiftCount  out  shifts since last load/clear, saturates at WIDTH
//   Drained     out  ShiftCount == WIDTH
module shift_register_universal #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Enable,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SerialInL,
  input  logic             SerialInR,
  output logic [WIDTH-1:0] Q,
  output logic             SerialOut,
  output logic [CW-1:0]    ShiftCount,
  output logic             Drained
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_LOAD  = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
`ifdef ARITH_SHIFT_EN
  localparam logic [2:0] MODE_ASHR  = 3'b110;
`endif

  localparam logic [CW-1:0] COUNT_FULL = CW'(WIDTH);

  logic [WIDTH-1:0] q_next;
  logic             so_next;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    cnt_inc;

  // Count never wraps: once full it sticks until a load or clear.
  assign cnt_inc = (ShiftCount == COUNT_FULL) ? ShiftCount : ShiftCount + 1'b1;

  always_comb begin
    q_next   = Q;
    so_next  = SerialOut;
    cnt_next = ShiftCount;
    case (Mode)
      MODE_SHL: begin
        q_next   = {Q[WIDTH-2:0], SerialInR};
        so_next  = Q[WIDTH-1];
        cnt_next = cnt_inc;
      end
      MODE_SHR: begin
        q_next   = {SerialInL, Q[WIDTH-1:1]};
        so_next  = Q[0];
        cnt_next = cnt_inc;
      end
      MODE_LOAD: begin
        q_next   = D;
        so_next  = 1'b0;
        cnt_next = '0;
      end
      MODE_ROTL: begin
        q_next  = {Q[WIDTH-2:0], Q[WIDTH-1]};
        so_next = Q[WIDTH-1];
      end
      MODE_ROTR: begin
        q_next  = {Q[0], Q[WIDTH-1:1]};
        so_next = Q[0];
      end
`ifdef ARITH_SHIFT_EN
      MODE_ASHR: begin
        q_next   = {Q[WIDTH-1], Q[WIDTH-1:1]};
        so_next  = Q[0];
        cnt_next = cnt_inc;
      end
`endif
      default: begin
        // MODE_HOLD, reserved 111, and 110 when arithmetic shift is absent
        q_next   = Q;
        so_next  = SerialOut;
        cnt_next = ShiftCount;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      Q          <= '0;
      SerialOut  <= 1'b0;
      ShiftCount <= '0;
    end else if (Enable) begin
      Q          <= q_next;
      SerialOut  <= so_next;
      ShiftCount <= cnt_next;
    end
  end

  // Decoded from the count register only, so no input reaches this output.
  assign Drained = (ShiftCount == COUNT_FULL);

endmodule

// File: tb/tb_shift_register_universal.sv
module tb_shift_register_universal;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             Clock = 1'b0;
  logic             Clear;
  logic             Enable;
  logic [2:0]       Mode;
  logic [WIDTH-1:0] D;
  logic             SerialInL;
  logic             SerialInR;
  logic [WIDTH-1:0] Q;
  logic             SerialOut;
  logic [CW-1:0]    ShiftCount;
  logic             Drained;

  shift_register_universal #(.WIDTH(WIDTH)) dut (
    .Clock      (Clock),
    .Clear      (Clear),
    .Enable     (Enable),
    .Mode       (Mode),
    .D          (D),
    .SerialInL  (SerialInL),
    .SerialInR  (SerialInR),
    .Q          (Q),
    .SerialOut  (SerialOut),
    .ShiftCount (ShiftCount),
    .Drained    (Drained)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       clr;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] q;
    logic       so;
    logic [3:0] cnt;
    logic       dr;
  } vec_t;

  typedef struct {
    int         step;
    logic [7:0] q;
    logic       so;
    logic [3:0] cnt;
    logic       dr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int step     = 0;

  function automatic vec_t mk(logic clr, logic en, logic [2:0] mode, logic [7:0] d,
                              logic sl, logic sr, logic [7:0] q, logic so,
                              logic [3:0] cnt, logic dr);
    vec_t v;
    v.clr = clr; v.en = en; v.mode = mode; v.d = d; v.sl = sl; v.sr = sr;
    v.q = q; v.so = so; v.cnt = cnt; v.dr = dr;
    return v;
  endfunction

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty step %0d", step);
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (Q !== e.q) begin
      n_fail++;
      $display("FAIL q step %0d: got %h want %h", e.step, Q, e.q);
    end
    n_checks++;
    if (SerialOut !== e.so) begin
      n_fail++;
      $display("FAIL serialout step %0d: got %b want %b", e.step, SerialOut, e.so);
    end
    n_checks++;
    if (ShiftCount !== e.cnt) begin
      n_fail++;
      $display("FAIL shiftcount step %0d: got %0d want %0d", e.step, ShiftCount, e.cnt);
    end
    n_checks++;
    if (Drained !== e.dr) begin
      n_fail++;
      $display("FAIL drained step %0d: got %b want %b", e.step, Drained, e.dr);
    end
  endtask

  // Drive one cycle, queue its expectation, compare just after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    Clear = v.clr; Enable = v.en; Mode = v.mode; D = v.d;
    SerialInL = v.sl; SerialInR = v.sr;
    e.step = step; e.q = v.q; e.so = v.so; e.cnt = v.cnt; e.dr = v.dr;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    check_out();
    step++;
  endtask

  // Independent behavioural model for the randomised sequence.
  logic [7:0] m_q;
  logic       m_so;
  logic [3:0] m_cnt;

  task automatic model_step(input vec_t v);
    logic [7:0] q0;
    q0 = m_q;
    if (v.clr) begin
      m_q = 8'h00; m_so = 1'b0; m_cnt = 4'd0;
    end else if (v.en) begin
      case (v.mode)
        3'd1: begin m_q = (q0 << 1) | {7'd0, v.sr}; m_so = q0[7];
                    if (m_cnt < 4'd8) m_cnt = m_cnt + 4'd1; end
        3'd2: begin m_q = (q0 >> 1) | {v.sl, 7'd0}; m_so = q0[0];
                    if (m_cnt < 4'd8) m_cnt = m_cnt + 4'd1; end
        3'd3: begin m_q = v.d; m_so = 1'b0; m_cnt = 4'd0; end
        3'd4: begin m_q = (q0 << 1) | (q0 >> 7); m_so = q0[7]; end
        3'd5: begin m_q = (q0 >> 1) | (q0 << 7); m_so = q0[0]; end
`ifdef ARITH_SHIFT_EN
        3'd6: begin m_q = (q0 >> 1) | (q0 & 8'h80); m_so = q0[0];
                    if (m_cnt < 4'd8) m_cnt = m_cnt + 4'd1; end
`endif
        default: ;
      endcase
    end
  endtask

  localparam logic [2:0] HLD = 3'd0, SHL = 3'd1, SHR = 3'd2, LD = 3'd3,
                         ROL = 3'd4, ROR = 3'd5, M6 = 3'd6, M7 = 3'd7;

  initial begin
    logic [7:0] a6_q;
    logic [3:0] a6_c;
    Clear = 1'b1; Enable = 1'b0; Mode = HLD; D = '0; SerialInL = 1'b0; SerialInR = 1'b0;

`ifdef ARITH_SHIFT_EN
    a6_q = 8'hC0; a6_c = 4'd1;
`else
    a6_q = 8'h80; a6_c = 4'd0;
`endif

    // clear beats enabled load
    vecs.push_back(mk(1, 1, LD,  8'hFF, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, LD,  8'hA5, 0, 0, 8'hA5, 0, 0, 0));
    vecs.push_back(mk(0, 1, SHL, 8'h00, 0, 1, 8'h4B, 1, 1, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, SHR, 8'h33, 1, 0, 8'h4B, 1, 1, 0));
    vecs.push_back(mk(0, 1, LD,  8'h81, 0, 0, 8'h81, 0, 0, 0));
    vecs.push_back(mk(0, 1, ROR, 8'h00, 0, 0, 8'hC0, 1, 0, 0));
    vecs.push_back(mk(0, 1, ROL, 8'h00, 0, 0, 8'h81, 1, 0, 0));
    vecs.push_back(mk(0, 1, LD,  8'hFF, 0, 0, 8'hFF, 0, 0, 0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 1, SHR, 8'h00, 0, 0, 8'(8'hFF >> k), 1, 4'(k), k == 8));
    vecs.push_back(mk(0, 1, SHR, 8'h00, 0, 0, 8'h00, 0, 8, 1));
    // rotate leaves a saturated count alone
    vecs.push_back(mk(0, 1, ROL, 8'h00, 0, 0, 8'h00, 0, 8, 1));
    vecs.push_back(mk(0, 1, LD,  8'h01, 0, 0, 8'h01, 0, 0, 0));
    vecs.push_back(mk(0, 1, LD,  8'h80, 0, 0, 8'h80, 0, 0, 0));
    vecs.push_back(mk(0, 1, M6,  8'h00, 1, 1, a6_q,  0, a6_c, 0));
    vecs.push_back(mk(0, 1, M7,  8'hFF, 1, 1, a6_q,  0, a6_c, 0));
    vecs.push_back(mk(0, 1, HLD, 8'hFF, 1, 1, a6_q,  0, a6_c, 0));
    vecs.push_back(mk(0, 1, LD,  8'h0F, 0, 0, 8'h0F, 0, 0, 0));
    vecs.push_back(mk(0, 1, SHL, 8'h00, 0, 0, 8'h1E, 0, 1, 0));
    vecs.push_back(mk(0, 1, SHL, 8'h00, 0, 0, 8'h3C, 0, 2, 0));
    vecs.push_back(mk(0, 1, SHL, 8'h00, 0, 0, 8'h78, 0, 3, 0));
    vecs.push_back(mk(1, 1, SHL, 8'h00, 0, 1, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, SHL, 8'h00, 0, 1, 8'h01, 0, 1, 0));
    // clear also beats Enable low
    vecs.push_back(mk(0, 1, LD,  8'h55, 0, 0, 8'h55, 0, 0, 0));
    vecs.push_back(mk(1, 0, LD,  8'hAA, 0, 0, 8'h00, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Hand sequence: shift left to full with serial ones, then rotate right
    // out a 1 bit while saturated.
    apply(mk(0, 1, LD, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    for (int k = 1; k <= 8; k++)
      apply(mk(0, 1, SHL, 8'h00, 0, 1, 8'((16'h00FF << k) >> 8) ^ 8'h00 | 8'((1 << k) - 1), 0, 4'(k), k == 8));
    apply(mk(0, 1, ROR, 8'h00, 0, 0, 8'hFF, 1, 8, 1));
    apply(mk(0, 1, SHL, 8'h00, 0, 0, 8'hFE, 1, 8, 1));

    // Randomised sequence against the behavioural model.
    m_q = 8'h00; m_so = 1'b0; m_cnt = 4'd0;
    apply(mk(1, 1, SHL, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    for (int i = 0; i < 200; i++) begin
      vec_t v;
      v = mk($urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0,
             3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom),
             0, 0, 0, 0);
      model_step(v);
      v.q = m_q; v.so = m_so; v.cnt = m_cnt; v.dr = (m_cnt == 4'd8);
      apply(v);
    end

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_register_universal.md
# shift_register_universal

Parametrised universal register: a WIDTH-bit clocked store that holds, loads in parallel, shifts logically in either direction, or rotates in either direction. It keeps a saturating count of bits shifted out since the last load. It is the next generation of the team's fixed 4-bit D flip-flop register and sits in the same datapath positions: operand staging, serialisers/deserialisers and bit-serial arithmetic.

## Interface
Parameters:
- WIDTH, 8, data width in bits; legal range ≥ 2.
- CW, $clog2(WIDTH+1), derived width of ShiftCount; do not override.

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- Clear  input  1  reset: synchronous and active-high; clears all state on the next rising edge.
- Enable  input  1  when low, all state holds; when high, Mode is acted on.
- Mode  input  3  operation select (see Operation).
- D  input  WIDTH  parallel load data.
- SerialInL  input  1  bit entering at the MSB on right shifts.
- SerialInR  input  1  bit entering at the LSB on left shifts.
- Q  output  WIDTH  register contents.
- SerialOut  output  1  last bit shifted or rotated out.
- ShiftCount  output  CW  number of shifts since the last load or clear; saturates at WIDTH.
- Drained  output  1  high when ShiftCount == WIDTH.

## Operation
- Priority: Clear > Enable low > Mode.
- Clear=1: Q=0, SerialOut=0, ShiftCount=0. Mode and Enable are ignored.
- Enable=0: Q, SerialOut and ShiftCount hold.
- Mode 000, hold: no state changes.
- Mode 001, shift left:
  - Q ← {Q[WIDTH-2:0], SerialInR}.
  - SerialOut ← Q[WIDTH-1].
  - ShiftCount increments, saturating at WIDTH.
- Mode 010, shift right:
  - Q ← {SerialInL, Q[WIDTH-1:1]}.
  - SerialOut ← Q[0].
  - ShiftCount increments, saturating at WIDTH.
- Mode 011, parallel load:
  - Q ← D.
  - SerialOut ← 0.
  - ShiftCount ← 0.
- Mode 100, rotate left:
  - Q ← {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - SerialOut ← Q[WIDTH-1].
  - ShiftCount unchanged.
- Mode 101, rotate right:
  - Q ← {Q[0], Q[WIDTH-1:1]}.
  - SerialOut ← Q[0].
  - ShiftCount unchanged.
- Mode 110: arithmetic right shift or hold (see Configuration).
- Mode 111: reserved; behaves as hold.
- Saturation: a shift at ShiftCount == WIDTH still updates Q and SerialOut, but the count stays at WIDTH. ShiftCount never wraps.
- Drained is a pure decode of ShiftCount. It falls only on load or Clear.

## Timing
- Every operation completes in 1 cycle: Q, SerialOut and ShiftCount reflect an operation on the edge that samples it.
- Q, SerialOut and ShiftCount are registered. Drained is combinational from the ShiftCount register only (no input-to-output path).
- Reset values: Q=0, SerialOut=0, ShiftCount=0, Drained=0.
- Clear asserted mid-sequence (e.g. after 3 of 8 shifts) takes effect on the next edge. The sequence does not resume.
- Clear and Enable/Mode asserted in the same cycle: Clear wins.
- No power-up assumption: state is undefined until the first edge with Clear=1.

## Configuration
- Macro ARITH_SHIFT_EN defined: Mode 110 is arithmetic right shift.
  - Q ← {Q[WIDTH-1], Q[WIDTH-1:1]}; SerialInL is ignored.
  - SerialOut ← Q[0].
  - ShiftCount increments, saturating at WIDTH.
- Macro not defined: Mode 110 is treated exactly as hold. No logic is generated for sign replication.

## Test plan
All scenarios use WIDTH=8.
- Clear=1 for 1 edge with Enable=1, Mode=011, D=8'hFF -> Q=8'h00, SerialOut=0, ShiftCount=0, Drained=0.
- Load 8'hA5, then shift left with SerialInR=1 -> Q=8'h4B, SerialOut=1, ShiftCount=1. Then Enable=0 for 3 cycles -> all outputs unchanged.
- Load 8'h81, then rotate right -> Q=8'hC0, SerialOut=1, ShiftCount=0. Then rotate left -> Q=8'h81, SerialOut=1.
- Load 8'hFF, then 8 right shifts with SerialInL=0 -> Q=8'h00, ShiftCount=8, Drained=1. A 9th shift -> ShiftCount stays 8. Load 8'h01 -> ShiftCount=0, Drained=0.
- Load 8'h80, then Mode=110:
  - With ARITH_SHIFT_EN -> Q=8'hC0, SerialOut=0, ShiftCount=1.
  - Without it -> Q=8'h80, ShiftCount=0.
- Load 8'h0F, 3 left shifts with SerialInR=0, then Clear=1 together with Mode=001 -> next edge gives Q=8'h00, ShiftCount=0.
